// File: rtl/s4ga_pkg.sv
// s4ga_pkg: constant functions and derived sizes shared by the serial LUT fabric
package s4ga_pkg;
   typedef enum logic {PH_IDX, PH_MASK} phase_e;
   function automatic int segs(input int w, input int si_w);
      return (w + si_w - 1) / si_w;
   endfunction
   function automatic int maxi(input int a, input int b);
      return a > b ? a : b;
   endfunction
   function automatic int idx_w(input int n, input int i);
      return $clog2(3 + i + n);
   endfunction
   function automatic int idx_segs(input int n, input int i, input int si_w);
      return segs(idx_w(n, i), si_w);
   endfunction
   function automatic int mask_segs(input int k, input int si_w);
      return segs(1 << k, si_w);
   endfunction
   function automatic int lut_len(input int n, input int k, input int i, input int si_w);
      return k * idx_segs(n, i, si_w) + mask_segs(k, si_w);
   endfunction
   function automatic int seg_w(input int n, input int k, input int i, input int si_w);
      return maxi(1, $clog2(maxi(idx_segs(n, i, si_w), mask_segs(k, si_w))));
   endfunction
endpackage

// File: rtl/s4ga_mask_match.sv
// s4ga_mask_match: flags the mask segment holding the addressed LUT and half-LUT bits
module s4ga_mask_match #(
   parameter int K     = 5,
   parameter int SI_W  = 4,
   parameter int SEG_W = 2
) (
   input  logic [K-1:0]     ins,
   input  logic [SEG_W-1:0] seg,
   input  logic [SI_W-1:0]  si,
   output logic             lut_ce,
   output logic             lut,
   output logic             half_ce,
   output logic             half
);
   localparam int LS  = $clog2(SI_W);
   localparam int TOP = (1 << K) / SI_W - 1;
   logic [K-1:0] w_hins;
   logic [31:0]  w_rseg;
   // mask arrives most-significant segment first, so segment s holds block TOP-s
   always_comb begin
      w_hins  = {1'b0, ins[K-2:0]};
      w_rseg  = 32'(TOP) - 32'(seg);
      lut_ce  = (32'(ins) >> LS) == w_rseg;
      lut     = 1'(si >> (32'(ins) % SI_W));
      half_ce = (32'(w_hins) >> LS) == w_rseg;
      half    = 1'(si >> (32'(w_hins) % SI_W));
   end
endmodule

// File: rtl/s4ga_stream.sv
// s4ga_stream: streamed-configuration K-LUT fabric evaluating N LUTs per frame
module s4ga_stream
   import s4ga_pkg::*;
#(
   parameter int N    = 199,
   parameter int K    = 5,
   parameter int I    = 2,
   parameter int O    = 7,
   parameter int SI_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            si_valid,
   input  logic [SI_W-1:0] si,
   input  logic [I-1:0]    inputs,
   output logic [O-1:0]    outputs,
   output logic            frame_done,
   output logic            debug,
   output logic            debug_valid
);
   localparam int IDX_SEGS  = idx_segs(N, I, SI_W);
   localparam int MASK_SEGS = mask_segs(K, SI_W);
   localparam int LL        = lut_len(N, K, I, SI_W);
   localparam int SEG_W     = seg_w(N, K, I, SI_W);
   localparam int IW        = IDX_SEGS * SI_W;
   localparam int NW        = maxi(1, $clog2(N));
   localparam int KW        = $clog2(K + 1);

   logic [NW-1:0]    r_n, w_n;
   logic [KW-1:0]    r_k, w_k;
   logic [SEG_W-1:0] r_seg, w_seg;
   logic [K-1:0]     r_ins;
   logic [IW-1:0]    r_idx, w_idx;
   logic [I-1:0]     r_insnap, w_snap;
   logic [N-1:0]     r_luts, w_luts;
   logic [O-1:0]     r_out, w_taps;
   logic             r_q, r_lut_q, r_half_q, r_done, r_dbg, r_dbg_v;
   phase_e           w_ph;
   logic             w_seg_last, w_idx_last, w_lut_last, w_frame_end;
   logic             w_bit, w_lut, w_half, w_lut_ce, w_lut_b, w_half_ce, w_half_b;
   logic [31:0]      w_iv;

   s4ga_mask_match #(.K(K), .SI_W(SI_W), .SEG_W(SEG_W)) u_match (
      .ins(r_ins), .seg(r_seg), .si(si),
      .lut_ce(w_lut_ce), .lut(w_lut_b), .half_ce(w_half_ce), .half(w_half_b)
   );

   always_comb begin
      w_ph        = (r_k == KW'(K)) ? PH_MASK : PH_IDX;
      w_seg_last  = r_seg == SEG_W'(w_ph == PH_MASK ? MASK_SEGS - 1 : IDX_SEGS - 1);
      w_idx_last  = w_ph == PH_IDX && w_seg_last;
      w_lut_last  = w_ph == PH_MASK && w_seg_last;
      w_frame_end = w_lut_last && r_n == NW'(N - 1);
      w_snap      = (r_n == '0 && r_k == '0 && r_seg == '0) ? inputs : r_insnap;
      w_idx       = (r_idx << SI_W) | IW'(si);
      w_iv        = 32'(w_idx);
      w_bit       = w_iv < 2 ? w_iv[0] :
                    w_iv == 2 ? r_q :
                    w_iv < 3 + I ? 1'(w_snap >> (w_iv - 3)) :
                    w_iv < 3 + I + N ? 1'(r_luts >> (w_iv - 3 - I)) : 1'b0;
      w_lut       = w_lut_ce ? w_lut_b : r_lut_q;
      w_half      = w_half_ce ? w_half_b : r_half_q;
      w_luts      = {r_luts[N-2:0], w_lut_last ? w_lut : r_luts[N-1]};
      w_seg       = w_seg_last ? '0 : r_seg + SEG_W'(1);
      w_k         = !w_seg_last ? r_k : w_ph == PH_MASK ? '0 : r_k + KW'(1);
      w_n         = !w_lut_last ? r_n : w_frame_end ? '0 : r_n + NW'(1);
   end

   // LUT N-1-j sits LL*j places past the injection point once the frame-end shift lands
   for (genvar j = 0; j < O; j++) begin : g_tap
      assign w_taps[j] = w_luts[(LL * j) % N];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_n      <= '0;
         r_k      <= '0;
         r_seg    <= '0;
         r_idx    <= '0;
         r_ins    <= '0;
         r_insnap <= '0;
         r_luts   <= '0;
         r_out    <= '0;
         r_q      <= 1'b0;
         r_lut_q  <= 1'b0;
         r_half_q <= 1'b0;
         r_done   <= 1'b0;
         r_dbg    <= 1'b0;
         r_dbg_v  <= 1'b0;
      end else begin
         r_done  <= si_valid && w_frame_end;
         r_dbg_v <= si_valid && (w_idx_last || w_lut_last);
         r_dbg   <= si_valid && (w_idx_last ? w_bit : w_lut_last && w_lut);
         if (si_valid) begin
            r_n      <= w_n;
            r_k      <= w_k;
            r_seg    <= w_seg;
            r_idx    <= w_idx;
            r_luts   <= w_luts;
            r_insnap <= w_snap;
            if (w_idx_last) r_ins <= {r_ins[K-2:0], w_bit};
            if (w_ph == PH_MASK && w_lut_ce) r_lut_q <= w_lut_b;
            if (w_ph == PH_MASK && w_half_ce) r_half_q <= w_half_b;
            if (w_lut_last) r_q <= w_half;
            if (w_frame_end) r_out <= w_taps;
         end
      end
   end

   assign outputs     = r_out;
   assign frame_done  = r_done;
   assign debug       = r_dbg;
   assign debug_valid = r_dbg_v;
endmodule

// File: tb/tb_s4ga_stream.sv
// tb_s4ga_stream: scoreboard bench for s4ga_stream in the small N=7, K=4 configuration
module tb_s4ga_stream;
   localparam int N = 7, K = 4, I = 2, O = 3, SI_W = 4, LL = 8;

   logic            clk = 1'b0, rst = 1'b1, si_valid = 1'b0;
   logic [SI_W-1:0] si = '0;
   logic [I-1:0]    inputs = '0;
   logic [O-1:0]    outputs;
   logic            frame_done, debug, debug_valid;

   int checks = 0, errors = 0;
   logic [3:0]  cfg_idx [N][K];
   logic [15:0] cfg_mask [N];
   logic        m_q = 1'b0;
   logic [1:0]  exp_dbg[$], obs_dbg[$];
   logic [2:0]  exp_out[$], obs_out[$];
   int          obs_done[$];

   always #5 clk = ~clk;

   s4ga_stream #(.N(N), .K(K), .I(I), .O(O), .SI_W(SI_W)) dut (
      .clk(clk), .rst(rst), .si_valid(si_valid), .si(si), .inputs(inputs),
      .outputs(outputs), .frame_done(frame_done), .debug(debug), .debug_valid(debug_valid)
   );

   task automatic set_lut(input int m, input logic [3:0] a, b, c, d, input logic [15:0] mk);
      cfg_idx[m][0] = a; cfg_idx[m][1] = b; cfg_idx[m][2] = c; cfg_idx[m][3] = d;
      cfg_mask[m] = mk;
   endtask

   task automatic set_all(input logic [3:0] a, b, c, d, input logic [15:0] mk);
      for (int m = 0; m < N; m++) set_lut(m, a, b, c, d, mk);
   endtask

   task automatic do_reset();
      rst = 1'b1; si_valid = 1'b1; si = 4'($urandom);
      @(posedge clk); #1;
      rst = 1'b0; si_valid = 1'b0; m_q = 1'b0;
   endtask

   // drives up to 'stop' accepted segments; the model pushes expected debug/outputs as it goes
   task automatic send_frame(input int stop, input int vpct, input logic [1:0] in_a, input logic [1:0] in_b, input int sw);
      int acc = 0;
      int stalls;
      logic [1:0] snap;
      logic [3:0] ins, s;
      logic bitv, lv;
      logic [2:0] eo = '0;
      exp_dbg.delete(); obs_dbg.delete(); exp_out.delete(); obs_out.delete(); obs_done.delete();
      snap = in_a;
      for (int m = 0; m < N && acc < stop; m++) begin
         ins = '0;
         for (int t = 0; t < LL && acc < stop; t++) begin
            stalls = 0;
            while (stalls < 20 && $urandom_range(99) >= vpct) begin
               si_valid = 1'b0; si = 4'($urandom);
               @(posedge clk); #1;
               stalls++;
               if (frame_done) begin obs_done.push_back(acc); obs_out.push_back(outputs); end
            end
            inputs = (acc >= sw) ? in_b : in_a;
            s = t < K ? cfg_idx[m][t] : 4'(cfg_mask[m] >> (4 * (LL - 1 - t)));
            if (t < K) begin
               bitv = s == 0 ? 1'b0 : s == 1 ? 1'b1 : s == 2 ? m_q : s == 3 ? snap[0] : s == 4 ? snap[1] : 1'b0;
               ins = {ins[2:0], bitv};
               exp_dbg.push_back({1'b1, bitv});
            end else if (t < LL - 1) begin
               exp_dbg.push_back(2'b00);
            end else begin
               lv = cfg_mask[m][ins];
               m_q = cfg_mask[m][{1'b0, ins[2:0]}];
               exp_dbg.push_back({1'b1, lv});
               if (m >= N - O) eo[N-1-m] = lv;
               if (m == N - 1) exp_out.push_back(eo);
            end
            si_valid = 1'b1; si = s;
            @(posedge clk); #1;
            acc++;
            obs_dbg.push_back({debug_valid, debug});
            if (frame_done) begin obs_done.push_back(acc); obs_out.push_back(outputs); end
         end
      end
      si_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 3;
      if (outputs !== 3'b000) begin errors++; $display("FAIL reset_outputs: got %b want 000", outputs); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
      if (debug_valid !== 1'b0) begin errors++; $display("FAIL reset_dbgv: got %b want 0", debug_valid); end
   endtask

   task automatic test_constants();
      logic [1:0] e, o;
      set_all(4'd1, 4'd1, 4'd1, 4'd1, 16'h8000);
      send_frame(1000, 100, 2'b00, 2'b00, 1000);
      checks += 3;
      if (obs_done.size() != 1 || obs_done[0] != N * LL) begin errors++; $display("FAIL const_done: got %0d pulses first at %0d, want 1 at %0d", obs_done.size(), obs_done[0], N * LL); end
      if (obs_out[0] !== exp_out[0]) begin errors++; $display("FAIL const_out: got %b want %b", obs_out[0], exp_out[0]); end
      if (obs_out[0] !== 3'b111) begin errors++; $display("FAIL const_out_lit: got %b want 111", obs_out[0]); end
      while (exp_dbg.size() != 0 && obs_dbg.size() != 0) begin
         e = exp_dbg.pop_front(); o = obs_dbg.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL const_dbg: got %b want %b", o, e); end
      end
      set_all(4'd1, 4'd1, 4'd1, 4'd1, 16'h7FFF);
      send_frame(1000, 100, 2'b00, 2'b00, 1000);
      checks += 2;
      if (obs_done.size() != 1 || obs_done[0] != N * LL) begin errors++; $display("FAIL b2b_done: got %0d pulses first at %0d, want 1 at %0d", obs_done.size(), obs_done[0], N * LL); end
      if (obs_out[0] !== 3'b000) begin errors++; $display("FAIL b2b_out: got %b want 000", obs_out[0]); end
   endtask

   task automatic test_snapshot();
      logic [1:0] e, o;
      set_all(4'd0, 4'd0, 4'd0, 4'd0, 16'h0000);
      set_lut(6, 4'd0, 4'd0, 4'd0, 4'd3, 16'h0002);
      send_frame(1000, 100, 2'b01, 2'b00, 10);
      checks += 2;
      if (obs_out[0] !== exp_out[0]) begin errors++; $display("FAIL snap_out: got %b want %b", obs_out[0], exp_out[0]); end
      if (obs_out[0][0] !== 1'b1) begin errors++; $display("FAIL snap_out0: got %b want 1", obs_out[0][0]); end
      while (exp_dbg.size() != 0 && obs_dbg.size() != 0) begin
         e = exp_dbg.pop_front(); o = obs_dbg.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL snap_dbg: got %b want %b", o, e); end
      end
      send_frame(1000, 100, 2'b00, 2'b00, 1000);
      checks++;
      if (obs_out[0] !== 3'b000) begin errors++; $display("FAIL snap_next: got %b want 000", obs_out[0]); end
   endtask

   task automatic test_half_q();
      logic [1:0] e, o;
      set_all(4'd0, 4'd0, 4'd0, 4'd0, 16'h0000);
      set_lut(0, 4'd1, 4'd0, 4'd0, 4'd0, 16'h0100);
      set_lut(1, 4'd0, 4'd0, 4'd0, 4'd2, 16'h0002);
      send_frame(1000, 100, 2'b00, 2'b00, 1000);
      checks += 2;
      if (obs_dbg[LL-1] !== 2'b11) begin errors++; $display("FAIL half_lut0: got %b want 11", obs_dbg[LL-1]); end
      if (obs_dbg[2*LL-1] !== 2'b10) begin errors++; $display("FAIL half_lut1: got %b want 10", obs_dbg[2*LL-1]); end
      while (exp_dbg.size() != 0 && obs_dbg.size() != 0) begin
         e = exp_dbg.pop_front(); o = obs_dbg.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL half_dbg: got %b want %b", o, e); end
      end
      set_lut(0, 4'd1, 4'd0, 4'd0, 4'd0, 16'h0001);
      send_frame(1000, 100, 2'b00, 2'b00, 1000);
      checks += 2;
      if (obs_dbg[2*LL-1] !== 2'b11) begin errors++; $display("FAIL q_lut1: got %b want 11", obs_dbg[2*LL-1]); end
      if (obs_dbg[2*LL-2] !== exp_dbg[2*LL-2]) begin errors++; $display("FAIL q_mask_dbg: got %b want %b", obs_dbg[2*LL-2], exp_dbg[2*LL-2]); end
   endtask

   task automatic test_bounds();
      set_all(4'd0, 4'd0, 4'd0, 4'd0, 16'h0000);
      set_lut(4, 4'd0, 4'd0, 4'd4, 4'd4, 16'h0008);
      set_lut(5, 4'd15, 4'd12, 4'd1, 4'd1, 16'h0008);
      send_frame(1000, 100, 2'b10, 2'b10, 1000);
      checks += 2;
      if (obs_out[0] !== exp_out[0]) begin errors++; $display("FAIL bounds_out: got %b want %b", obs_out[0], exp_out[0]); end
      if (obs_out[0] !== 3'b110) begin errors++; $display("FAIL bounds_lit: got %b want 110", obs_out[0]); end
   endtask

   task automatic test_stall();
      logic [1:0] e, o;
      set_all(4'd1, 4'd1, 4'd1, 4'd1, 16'h8000);
      send_frame(1000, 50, 2'b00, 2'b00, 1000);
      checks += 2;
      if (obs_done.size() != 1 || obs_done[0] != N * LL) begin errors++; $display("FAIL stall_done: got %0d pulses first at %0d, want 1 at %0d", obs_done.size(), obs_done[0], N * LL); end
      if (obs_out[0] !== 3'b111) begin errors++; $display("FAIL stall_out: got %b want 111", obs_out[0]); end
      while (exp_dbg.size() != 0 && obs_dbg.size() != 0) begin
         e = exp_dbg.pop_front(); o = obs_dbg.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL stall_dbg: got %b want %b", o, e); end
      end
      repeat (3) @(posedge clk);
      #1;
      checks += 2;
      if (outputs !== 3'b111) begin errors++; $display("FAIL stall_hold: got %b want 111", outputs); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL stall_pulse: got %b want 0", frame_done); end
   endtask

   task automatic test_mid_reset();
      set_all(4'd1, 4'd1, 4'd1, 4'd1, 16'h8000);
      set_lut(5, 4'd1, 4'd1, 4'd1, 4'd1, 16'h7FFF);
      send_frame(20, 100, 2'b00, 2'b00, 1000);
      checks++;
      if (obs_done.size() != 0) begin errors++; $display("FAIL mid_partial: got %0d pulses want 0", obs_done.size()); end
      do_reset();
      checks += 3;
      if (outputs !== 3'b000) begin errors++; $display("FAIL mid_rst_out: got %b want 000", outputs); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b want 0", frame_done); end
      if (debug_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_dbgv: got %b want 0", debug_valid); end
      send_frame(1000, 100, 2'b00, 2'b00, 1000);
      checks += 3;
      if (obs_done.size() != 1 || obs_done[0] != N * LL) begin errors++; $display("FAIL mid_done: got %0d pulses first at %0d, want 1 at %0d", obs_done.size(), obs_done[0], N * LL); end
      if (obs_out[0] !== exp_out[0]) begin errors++; $display("FAIL mid_out: got %b want %b", obs_out[0], exp_out[0]); end
      if (obs_out[0] !== 3'b101) begin errors++; $display("FAIL mid_out_lit: got %b want 101", obs_out[0]); end
   endtask

   initial begin
      test_reset();
      test_constants();
      test_snapshot();
      test_half_q();
      test_bounds();
      test_stall();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
